// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its sampler,
// deserializer and start/parity/stop checkers.
interface uart_rx_ctrl_if;
   logic       RX_IN;
   logic       PAR_EN;
   logic [5:0] Prescale;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en;
   logic       deser_en;
   logic       strt_chk_en;
   logic       par_chk_en;
   logic       stp_chk_en;
   logic       data_valid;
   logic       par_error;
   logic       frm_error;
   logic       rx_busy;

   modport slave (
      input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
             par_chk_en, stp_chk_en, data_valid, par_error, frm_error, rx_busy
   );

   modport master (
      output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
             par_chk_en, stp_chk_en, data_valid, par_error, frm_error, rx_busy
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: tracks oversample/bit position through a
// frame and issues sampler, deserializer and checker strobes.
module uart_rx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input logic           CLK,
   input logic           RST,
   uart_rx_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);

   state_t     state, state_nxt;
   logic [5:0] prescale_q;
   logic       par_en_q;
   logic [4:0] edge_q;
   logic [3:0] bit_q;
   logic       par_error_q, frm_error_q, data_valid_q;
   logic       bit_end, frame_start;
   logic       strt_chk, par_chk, stp_chk, valid_nxt;

   // 6-bit compare so a latched Prescale of 32 ends the bit at edge 31
   assign bit_end = ({1'b0, edge_q} == (prescale_q - 6'd1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      strt_chk    = 1'b0;
      par_chk     = 1'b0;
      stp_chk     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!bus.RX_IN) begin
               state_nxt   = START;
               frame_start = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               strt_chk  = 1'b1;
               state_nxt = bus.strt_glitch ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_end && (bit_q == LAST_DATA))
               state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            if (bit_end) begin
               par_chk   = 1'b1;
               state_nxt = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               stp_chk   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // par_error_q already holds this frame's parity result by the stop bit
      valid_nxt = stp_chk && !bus.stp_err && !par_error_q;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         edge_q       <= '0;
         bit_q        <= '0;
         prescale_q   <= 6'd8;
         par_en_q     <= 1'b0;
         par_error_q  <= 1'b0;
         frm_error_q  <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         data_valid_q <= valid_nxt;
         if (frame_start) begin
            edge_q      <= 5'd1;
            bit_q       <= '0;
            prescale_q  <= bus.Prescale;
            par_en_q    <= bus.PAR_EN;
            par_error_q <= 1'b0;
            frm_error_q <= 1'b0;
         end else if (state_nxt == IDLE) begin
            edge_q <= '0;
            bit_q  <= '0;
         end else if (bit_end) begin
            edge_q <= '0;
            bit_q  <= bit_q + 4'd1;
         end else begin
            edge_q <= edge_q + 5'd1;
         end
         if (par_chk) par_error_q <= bus.par_err;
         if (stp_chk) frm_error_q <= bus.stp_err;
      end
   end

   assign bus.edge_cnt    = edge_q;
   assign bus.bit_cnt     = bit_q;
   assign bus.dat_samp_en = (state != IDLE);
   assign bus.rx_busy     = (state != IDLE);
   assign bus.deser_en    = (state == DATA);
   assign bus.strt_chk_en = strt_chk;
   assign bus.par_chk_en  = par_chk;
   assign bus.stp_chk_en  = stp_chk;
   assign bus.data_valid  = data_valid_q;
   assign bus.par_error   = par_error_q;
   assign bus.frm_error   = frm_error_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, predicts per-frame timing,
// strobe counts and flags into a queue, and checks them as each frame ends.
module tb_uart_rx_ctrl;
   localparam int DW = 8;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   uart_rx_ctrl_if bus ();

   uart_rx_ctrl #(.DATA_WIDTH(DW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   typedef struct {
      int         p;
      bit         par_en;
      logic [7:0] data;
      bit         glitch, perr, serr;
      bit         exp_valid, exp_pe, exp_fe;
   } vec_t;

   typedef struct {
      int id;
      int busy_len, deser, strt, par, stp, max_edge, max_bit;
      bit valid, pe, fe;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];
   int   checks = 0, errors = 0;
   int   dv_total = 0, dv_exp = 0, frame_id = 0, idle_bad = 0;
   bit   mon_en = 1'b1, abort = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_frame(input int p, input bit par_en, input logic [7:0] data,
                             input bit glitch, input bit perr, input bit serr,
                             input bit push, input bit ev, input bit epe, input bit efe);
      int   nbits;
      exp_t e;
      logic lv;
      nbits = glitch ? 1 : (DW + 2 + (par_en ? 1 : 0));
      if (push) begin
         e.id       = frame_id;
         e.busy_len = nbits * p - 1;
         e.deser    = glitch ? 0 : DW * p;
         e.strt     = 1;
         e.par      = (!glitch && par_en) ? 1 : 0;
         e.stp      = glitch ? 0 : 1;
         e.max_edge = p - 1;
         e.max_bit  = glitch ? 0 : (DW + 1 + (par_en ? 1 : 0));
         e.valid    = ev;
         e.pe       = epe;
         e.fe       = efe;
         sb.push_back(e);
         dv_exp += ev ? 1 : 0;
      end
      frame_id++;
      bus.strt_glitch = glitch;
      bus.par_err     = perr;
      bus.stp_err     = serr;
      for (int b = 0; b < nbits; b++) begin
         if (b == 0)                        lv = 1'b0;
         else if (b <= DW)                  lv = data[b-1];
         else if (par_en && (b == DW + 1))  lv = ^data;
         else                               lv = 1'b1;
         for (int c = 0; c < p; c++) begin
            if (abort) begin
               bus.RX_IN = 1'b1;
               return;
            end
            bus.RX_IN = (glitch && c >= 3) ? 1'b1 : lv;
            @(negedge CLK);
         end
      end
      bus.RX_IN = 1'b1;
   endtask

   // Per-frame monitor, sampled on the falling edge
   int busy_len, deser_n, strt_n, par_n, stp_n, max_edge, max_bit;
   bit prev_busy = 1'b0;
   exp_t cur;

   always @(negedge CLK) begin
      if (!RST) begin
         prev_busy = 1'b0;
      end else begin
         if (bus.rx_busy && !prev_busy) begin
            busy_len = 0; deser_n = 0; strt_n = 0; par_n = 0; stp_n = 0;
            max_edge = 0; max_bit = 0;
         end
         if (bus.rx_busy) begin
            busy_len++;
            if (bus.deser_en)    deser_n++;
            if (bus.strt_chk_en) strt_n++;
            if (bus.par_chk_en)  par_n++;
            if (bus.stp_chk_en)  stp_n++;
            if (int'(bus.edge_cnt) > max_edge) max_edge = int'(bus.edge_cnt);
            if (int'(bus.bit_cnt) > max_bit)   max_bit  = int'(bus.bit_cnt);
         end else begin
            if (bus.deser_en || bus.dat_samp_en || bus.strt_chk_en ||
                bus.par_chk_en || bus.stp_chk_en || bus.edge_cnt != 0 || bus.bit_cnt != 0)
               idle_bad++;
         end
         if (bus.data_valid) dv_total++;
         if (!bus.rx_busy && prev_busy && mon_en) begin
            if (sb.size() == 0) begin
               chk("unexpected_frame_end", 1, 0);
            end else begin
               cur = sb.pop_front();
               chk($sformatf("f%0d busy_len", cur.id), busy_len, cur.busy_len);
               chk($sformatf("f%0d deser_cycles", cur.id), deser_n, cur.deser);
               chk($sformatf("f%0d strt_strobes", cur.id), strt_n, cur.strt);
               chk($sformatf("f%0d par_strobes", cur.id), par_n, cur.par);
               chk($sformatf("f%0d stp_strobes", cur.id), stp_n, cur.stp);
               chk($sformatf("f%0d max_edge", cur.id), max_edge, cur.max_edge);
               chk($sformatf("f%0d max_bit", cur.id), max_bit, cur.max_bit);
               chk($sformatf("f%0d data_valid", cur.id), int'(bus.data_valid), int'(cur.valid));
               chk($sformatf("f%0d par_error", cur.id), int'(bus.par_error), int'(cur.pe));
               chk($sformatf("f%0d frm_error", cur.id), int'(bus.frm_error), int'(cur.fe));
            end
         end
         prev_busy = bus.rx_busy;
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, " rx_busy"},     int'(bus.rx_busy), 0);
      chk({tag, " edge_cnt"},    int'(bus.edge_cnt), 0);
      chk({tag, " bit_cnt"},     int'(bus.bit_cnt), 0);
      chk({tag, " deser_en"},    int'(bus.deser_en), 0);
      chk({tag, " dat_samp_en"}, int'(bus.dat_samp_en), 0);
      chk({tag, " strobes"},     int'({bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en}), 0);
      chk({tag, " data_valid"},  int'(bus.data_valid), 0);
      chk({tag, " flags"},       int'({bus.par_error, bus.frm_error}), 0);
   endtask

   bit found;

   initial begin
      //        p  par data   gl perr serr  valid pe fe
      vecs[0] = '{8,  0, 8'hA5, 0, 0, 0,    1, 0, 0};
      vecs[1] = '{16, 1, 8'h3C, 0, 1, 0,    0, 1, 0};
      vecs[2] = '{8,  0, 8'h00, 1, 0, 0,    0, 0, 0};
      vecs[3] = '{32, 0, 8'h5A, 0, 0, 1,    0, 0, 1};
      vecs[4] = '{16, 1, 8'hC3, 0, 0, 0,    1, 0, 0};
      vecs[5] = '{32, 1, 8'h81, 0, 0, 0,    1, 0, 0};
      vecs[6] = '{8,  1, 8'hFF, 0, 1, 1,    0, 1, 1};

      bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
      bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
      #1 chk_all_zero("reset");
      @(negedge CLK);
      RST = 1'b1;
      repeat (2) @(negedge CLK);

      for (int i = 0; i < 7; i++) begin
         bus.Prescale = 6'(vecs[i].p);
         bus.PAR_EN   = vecs[i].par_en;
         send_frame(vecs[i].p, vecs[i].par_en, vecs[i].data, vecs[i].glitch,
                    vecs[i].perr, vecs[i].serr, 1'b1,
                    vecs[i].exp_valid, vecs[i].exp_pe, vecs[i].exp_fe);
         repeat (4) @(negedge CLK);
      end

      // Back-to-back frames; Prescale/PAR_EN change while the first is running
      bus.Prescale = 6'd16;
      bus.PAR_EN   = 1'b0;
      fork
         begin
            send_frame(16, 0, 8'h69, 0, 0, 0, 1'b1, 1, 0, 0);
            send_frame(8,  0, 8'h96, 0, 0, 0, 1'b1, 1, 0, 0);
         end
         begin
            repeat (40) @(negedge CLK);
            bus.Prescale = 6'd8;
            bus.PAR_EN   = 1'b1;
            repeat (60) @(negedge CLK);
            bus.PAR_EN   = 1'b0;
         end
      join
      repeat (4) @(negedge CLK);

      // Asynchronous reset in the middle of the data bits
      mon_en = 1'b0;
      bus.Prescale = 6'd8;
      fork
         send_frame(8, 0, 8'h5C, 0, 0, 0, 1'b0, 0, 0, 0);
         begin
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
               @(negedge CLK);
               if (bus.deser_en && bus.bit_cnt == 4'd4) found = 1'b1;
            end
            chk("reach_data_bit4", int'(found), 1);
            #3 RST = 1'b0;
            abort = 1'b1;
            #1 chk_all_zero("async_rst");
         end
      join
      repeat (3) @(negedge CLK);
      chk_all_zero("rst_hold");
      RST = 1'b1;
      abort = 1'b0;
      repeat (3) @(negedge CLK);
      chk("idle_after_rst", int'(bus.rx_busy), 0);
      mon_en = 1'b1;
      send_frame(8, 0, 8'h3C, 0, 0, 0, 1'b1, 1, 0, 0);

      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge CLK);
      repeat (2) @(negedge CLK);
      chk("scoreboard_empty", sb.size(), 0);
      chk("data_valid_total", dv_total, dv_exp);
      chk("idle_outputs_quiet", idle_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame; legal range 5..8.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset; asynchronous, active-low.
REQ-004 RX_IN  input  1  serial line, idle high, already synchronised to CLK.
REQ-005 PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-006 Prescale  input  6  oversampling ratio; legal values 8, 16, 32.
REQ-007 strt_glitch  input  1  start checker result, valid in the strt_chk_en cycle.
REQ-008 par_err  input  1  parity checker result, valid in the par_chk_en cycle.
REQ-009 stp_err  input  1  stop checker result, valid in the stp_chk_en cycle.
REQ-010 edge_cnt  output  5  oversample index within the current bit, 0..Prescale-1.
REQ-011 bit_cnt  output  4  bit index within the frame: 0 = start, 1..DATA_WIDTH = data, then parity/stop.
REQ-012 dat_samp_en  output  1  enables the majority-vote sampler.
REQ-013 deser_en  output  1  enables the deserializer shift.
REQ-014 strt_chk_en, par_chk_en, stp_chk_en  output  1 each  single-cycle check strobes.
REQ-015 data_valid  output  1  one-cycle pulse: received byte is good.
REQ-016 par_error, frm_error  output  1 each  sticky error flags for the last frame.
REQ-017 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 States: IDLE, START, DATA, PARITY, STOP; binary encoding, one registered state.
REQ-019 Prescale and PAR_EN are latched on the IDLE->START transition; later changes have no effect until the next frame.
REQ-020 Define bit_end = (edge_cnt == latched Prescale - 1).
REQ-021 IDLE: edge_cnt = 0, bit_cnt = 0. When RX_IN == 0, go to START with edge_cnt loaded to 1, so the detection cycle counts as edge 0.
REQ-022 Outside IDLE: edge_cnt increments every cycle. At bit_end, edge_cnt wraps to 0 and bit_cnt increments.
REQ-023 START: at bit_end, strt_chk_en = 1. If strt_glitch, go to IDLE with no flag update and no data_valid; otherwise go to DATA.
REQ-024 DATA: deser_en = 1 for the whole state. At bit_end with bit_cnt == DATA_WIDTH, go to PARITY if latched PAR_EN, else to STOP.
REQ-025 PARITY: at bit_end, par_chk_en = 1, par_error <= par_err, then go to STOP.
REQ-026 STOP: at bit_end, stp_chk_en = 1, frm_error <= stp_err, then go to IDLE.
REQ-027 data_valid is registered: it is high in the first IDLE cycle after STOP only if stp_err == 0 at the stop strobe and par_error (as updated this frame) == 0.
REQ-028 dat_samp_en = 1 in all states except IDLE.
REQ-029 Strobes are combinational from state and bit_end: exactly one cycle per bit, never in IDLE.
REQ-030 par_error and frm_error are cleared on the IDLE->START transition and otherwise hold.
REQ-031 Back-to-back frames: RX_IN low in the data_valid cycle starts a new frame in that same cycle.
REQ-032 The edge_cnt wrap uses 6-bit compare arithmetic; with Prescale = 32, edge_cnt reaches 31 and wraps without overflow.

Reset
REQ-033 On RST low, immediately and regardless of CLK: state = IDLE, edge_cnt = 0, bit_cnt = 0, all strobes, enables and data_valid = 0, par_error = frm_error = 0, latched Prescale = 8, latched PAR_EN = 0.
REQ-034 Reset mid-frame abandons the frame: no data_valid and no flag update. After release, the block waits in IDLE for a new falling edge.

Verification
REQ-035 Prescale = 8, PAR_EN = 0, frame 0x A5 with good stop -> deser_en high for exactly 64 cycles; one data_valid pulse 80 cycles after the start-bit detect cycle (start + 8 data + stop = 10 bits x 8); flags 0.
REQ-036 Prescale = 16, PAR_EN = 1, par_err = 1 at the strobe -> par_error = 1, data_valid never asserts, state returns to IDLE after bit_cnt reaches 10.
REQ-037 Start glitch: RX_IN low for 3 cycles with strt_glitch = 1 at the strobe -> return to IDLE at edge 8 (Prescale = 8); no deser_en, no data_valid.
REQ-038 Prescale = 32, stp_err = 1 -> frm_error = 1, no data_valid; edge_cnt observed reaching 31 then 0.
REQ-039 Two back-to-back frames with Prescale changed 16->8 mid-frame -> first frame completes at 16 edges per bit, second frame runs at 8; two data_valid pulses.
REQ-040 RST asserted in DATA at bit_cnt = 4 -> all outputs 0 asynchronously; the next clean frame after release is received correctly.
